keypad_scanner: RTL and testbench

- Input-side counterpart of the 7-segment display driver: scans a 4x4 hex matrix keypad and debounces it.
- Delivers one 4-bit key code per physical press to the CPU I/O path over a valid/ready handshake.
- Active-low row drive and column sense, matching the board's active-low display/anode convention.
- With the optional accumulator, it also builds a 32-bit hex value suitable for the display's 32-bit data input.

---
 rtl/keypad_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce and a valid/ready key output.
// Define KEYPAD_ACCUM_EN to add a 32-bit hex shift accumulator (accum_value/accum_clr).
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        overflow
`ifdef KEYPAD_ACCUM_EN
    ,
    output logic [31:0] accum_value,
    input  logic        accum_clr
`endif
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state, state_n;
    logic [3:0]      col_m, col_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [1:0]      row_idx, row_n;
    logic [CW-1:0]   db_cnt, cnt_n, cnt_inc;
    logic [3:0]      ref_col, ref_n;
    logic [1:0]      col_idx;
    logic            sample_ok, all_high;
    logic            accept, consume, take;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    assign tick = (tick_cnt == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    always_comb begin
        sample_ok = 1'b1;
        col_idx   = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: sample_ok = 1'b0;
        endcase
    end

    assign all_high = &col_s;
    assign cnt_inc  = db_cnt + 1'b1;

    always_comb begin
        state_n = state;
        row_n   = row_idx;
        cnt_n   = db_cnt;
        ref_n   = ref_col;
        accept  = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (sample_ok) begin
                        ref_n = col_s;
                        cnt_n = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_n = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == ref_col) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                        end
                    end else begin
                        state_n = SCAN;
                        row_n   = row_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    if (all_high) begin
                        cnt_n = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_n = SCAN;
                            row_n   = row_idx + 2'd1;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            state_n = SCAN;
                            row_n   = row_idx + 2'd1;
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            row_idx <= '0;
            db_cnt  <= '0;
            ref_col <= '1;
        end else begin
            state   <= state_n;
            row_idx <= row_n;
            db_cnt  <= cnt_n;
            ref_col <= ref_n;
        end
    end

    assign row_out = ~(4'b0001 << row_idx);

    // A same-edge consume frees the slot, so the new key replaces the old one.
    assign consume = key_valid && key_ready;
    assign take    = accept && (!key_valid || consume);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (take) begin
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
            end else if (consume) begin
                key_valid <= 1'b0;
            end
            if (accept && !take) overflow <= 1'b1;
        end
    end

`ifdef KEYPAD_ACCUM_EN
    always_ff @(posedge clk) begin
        if (rst || accum_clr) accum_value <= '0;
        else if (take)        accum_value <= {accum_value[27:0], row_idx, col_idx};
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives col_in from row_out,
// expected key codes are queued per press and popped by a handshake monitor.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_out, col_in, key_code;
    logic        key_valid, overflow;
    logic        key_ready = 1'b0;
`ifdef KEYPAD_ACCUM_EN
    logic [31:0] accum_value;
    logic        accum_clr = 1'b0;
`endif

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .overflow(overflow)
`ifdef KEYPAD_ACCUM_EN
        , .accum_value(accum_value), .accum_clr(accum_clr)
`endif
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    logic        pressed = 1'b0;
    int unsigned prow = 0, pcol = 0;
    logic        raw_mode = 1'b0;
    logic [3:0]  raw_col = 4'hF;

    always_comb begin
        if (raw_mode) col_in = raw_col;
        else if (pressed && row_out[prow] == 1'b0) col_in = ~(4'b0001 << pcol);
        else col_in = 4'hF;
    end

    logic [3:0] exp_q[$];
    int         checks = 0, errors = 0, n_popped = 0;
    logic       rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic       prev_hold = 1'b0;
    logic [3:0] prev_code = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) check("code_stable", {27'd0, key_valid, key_code}, {27'd0, 1'b1, prev_code});
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got %0h expected none", key_code);
                end else begin
                    check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
                end
                n_popped++;
            end
        end
        prev_hold = !rst && key_valid && !key_ready;
        prev_code = key_code;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_row(input logic [3:0] v, input int max, output int el);
        el = 0;
        while (row_out !== v && el < max) begin
            step(1);
            el++;
        end
        check("wait_row", 32'(row_out), 32'(v));
    endtask

    task automatic wait_pop(input int target, input int max);
        int el = 0;
        while (n_popped < target && el < max) begin
            step(1);
            el++;
        end
        check("pop_count", n_popped, target);
    endtask

    task automatic press(input int unsigned r, input int unsigned c, input int hold);
        prow = r;
        pcol = c;
        pressed = 1'b1;
        step(hold);
        pressed = 1'b0;
    endtask

    task automatic count_row_changes(input int cycles, output int nchg);
        logic [3:0] last;
        int since;
        last = row_out;
        since = 0;
        nchg = 0;
        repeat (cycles) begin
            step(1);
            since++;
            check("row_onehot", $countones(~row_out), 1);
            if (row_out !== last) begin
                check("row_order", 32'(row_out), 32'({last[2:0], last[3]}));
                if (nchg > 0) check("row_period", since, 4);
                nchg++;
                since = 0;
                last = row_out;
            end
        end
    endtask

    initial begin
        int el, nchg, base, total;
        logic frozen;
        do_reset();

        check("rst_row", 32'(row_out), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_code", 32'(key_code), 0);

        count_row_changes(40, nchg);
        check("idle_changes", nchg, 10);
        check("idle_valid", 32'(key_valid), 0);

        // Single press of key 6 with consumer always ready.
        key_ready = 1'b1;
        base = n_popped;
        exp_q.push_back(4'b0110);
        prow = 1; pcol = 2; pressed = 1'b1;
        wait_pop(base + 1, 100);
        frozen = 1'b1;
        repeat (30) begin
            step(1);
            if (row_out !== 4'b1101) frozen = 1'b0;
        end
        check("row_frozen", 32'(frozen), 1);
        check("single_pulse_valid", 32'(key_valid), 0);
        pressed = 1'b0;
        wait_row(4'b1011, 60, el);
        check("release_delay", 32'(el >= 8), 1);

        // Bounce on row 0: two low ticks then high.
        wait_row(4'b0111, 20, el);
        wait_row(4'b1110, 20, el);
        raw_col = 4'b1110;
        raw_mode = 1'b1;
        step(8);
        raw_col = 4'hF;
        total = 8;
        while (row_out === 4'b1110 && total < 40) begin
            step(1);
            total++;
        end
        check("bounce_held", 32'(total >= 8), 1);
        check("bounce_next_row", 32'(row_out), 32'h0000000D);
        check("bounce_valid", 32'(key_valid), 0);
        check("bounce_pops", n_popped, base + 1);
        raw_mode = 1'b0;

        // Overflow: key 5 pending, key 10 dropped.
        key_ready = 1'b0;
        exp_q.push_back(4'b0101);
        press(1, 1, 80);
        step(40);
        press(2, 2, 80);
        step(40);
        check("ovf_valid", 32'(key_valid), 1);
        check("ovf_code", 32'(key_code), 5);
        check("ovf_flag", 32'(overflow), 1);
        key_ready = 1'b1;
        step(1);
        check("ovf_consumed", 32'(key_valid), 0);
        check("ovf_pops", n_popped, base + 2);
        step(20);
        check("ovf_sticky", 32'(overflow), 1);

        // Two columns low is never a key.
        do_reset();
        check("reset_clears_ovf", 32'(overflow), 0);
        raw_col = 4'b1001;
        raw_mode = 1'b1;
        base = n_popped;
        count_row_changes(80, nchg);
        check("invalid_changes", nchg, 20);
        check("invalid_pops", n_popped, base);
        check("invalid_valid", 32'(key_valid), 0);
        raw_mode = 1'b0;
        raw_col = 4'hF;
        step(10);

        // Random presses with a randomly stalling consumer.
        base = n_popped;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int unsigned r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            exp_q.push_back({r[1:0], c[1:0]});
            press(r, c, $urandom_range(60, 100));
            step($urandom_range(40, 70));
        end
        rand_ready = 1'b0;
        key_ready = 1'b1;
        wait_pop(base + 16, 100);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_overflow", 32'(overflow), 0);

        // Reset while a key waits for the consumer.
        key_ready = 1'b0;
        press(2, 1, 80);
        check("pend_valid", 32'(key_valid), 1);
        check("pend_code", 32'(key_code), 9);
        do_reset();
        check("mid_rst_valid", 32'(key_valid), 0);
        check("mid_rst_code", 32'(key_code), 0);
        check("mid_rst_row", 32'(row_out), 32'h0000000E);

`ifdef KEYPAD_ACCUM_EN
        key_ready = 1'b1;
        check("acc_rst", accum_value, 0);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(4'(k));
            press(k / 4, k % 4, 80);
            step(50);
        end
        check("acc_123", accum_value, 32'h00000123);
        wait_row(4'b1110, 20, el);
        prow = 1; pcol = 0; pressed = 1'b1;
        step(10);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        pressed = 1'b0;
        check("acc_mid_rst", accum_value, 0);
        check("acc_mid_valid", 32'(key_valid), 0);
        check("acc_mid_row", 32'(row_out), 32'h0000000E);
        check("acc_mid_ovf", 32'(overflow), 0);
        exp_q.push_back(4'd7);
        press(1, 3, 80);
        step(50);
        check("acc_7", accum_value, 32'h00000007);
        accum_clr = 1'b1;
        step(1);
        accum_clr = 1'b0;
        check("acc_clr", accum_value, 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
